mips_1stage_pc_unit: RTL and testbench
======================================

Name: mips_1stage_pc_unit

Overview:
Program-counter and next-PC stage of the single-cycle MIPS CPU. It feeds the instruction-memory address that produces the opcode/func fields for the decoder. It consumes the decoder's branch/jump/syscall controls plus ALU/register results to select the next PC. It owns the RUN/HALT machine and the cycle, jump and taken-branch statistics counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
IMEM_AW, 10, instruction-memory word-address width.
CNT_W, 32, width of each statistics counter.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_BEQ  in  1  decoder BEQ.
i_BNE  in  1  decoder BNE.
i_JUMP  in  1  decoder JUMP (asserted for J, JAL and JR).
i_JR  in  1  decoder JR.
i_halt_req  in  1  syscall with $v0==10 (SYSCALL & v0 check, formed outside).
i_alu_equal  in  1  ALU equal flag (rs==rt).
i_imm16  in  16  instruction [15:0].
i_jaddr26  in  26  instruction [25:0].
i_rs_data  in  32  register-file rs read value (JR target).
i_go  in  1  resume request (level, from a button or debounced switch).
o_pc  out  32  current PC.
o_pc_plus4  out  32  PC+4 (JAL link value).
o_imem_addr  out  IMEM_AW  o_pc[IMEM_AW+1:2].
o_halted  out  1  1 while in HALT.
o_cycle_cnt  out  CNT_W  cycles spent in RUN.
o_jump_cnt  out  CNT_W  executed J/JAL/JR.
o_branch_cnt  out  CNT_W  taken BEQ/BNE.

Behaviour:
- Reset (i_rst=1 at an edge):
  - pc=RESET_PC; state=RUN; all counters=0.
  - go-edge register cleared. Outputs follow, so o_halted=0.
  - Reset wins over every other event, including mid-HALT and the same cycle as i_halt_req.
- Combinational signals:
  - pc4 = pc + 32'd4 (mod 2^32).
  - btgt = pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - jtgt = {pc4[31:28], jaddr26, 2'b00}.
  - rtgt = {rs_data[31:2], 2'b00} (low bits forced to 0).
  - taken = (BEQ & alu_equal) | (BNE & ~alu_equal).
- Next-PC priority in RUN, without halt: JR -> rtgt; else JUMP -> jtgt; else taken -> btgt; else pc4.
- State RUN, each edge:
  - o_cycle_cnt += 1.
  - If i_halt_req: pc holds (stays at the syscall address), state -> HALT. Jump/branch counters are not updated.
  - Else: pc <= next-PC; o_jump_cnt += JUMP; o_branch_cnt += taken.
- State HALT:
  - pc and all counters hold; o_halted=1.
  - Resume on a rising edge of i_go, detected with a 1-flop history register (go_q). go_q updates every cycle, including in RUN.
  - On the edge: state -> RUN, pc <= pc4 (skips the syscall).
  - i_go held high from before the halt does not resume; it must go low, then high again.
- Latency: next-PC is visible on o_pc one cycle after the controls. o_imem_addr is combinational from pc.
- Wrap-around:
  - pc4 wraps 32'hFFFF_FFFC -> 0.
  - Counters wrap modulo 2^CNT_W; no saturation.
- Simultaneous events:
  - halt_req together with JUMP or taken: halt wins.
  - JR with BEQ (illegal from the decoder): JR wins.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum (ST_RUN, ST_HALT);
  - the opcode constants used by the decoder (OP_BEQ=4, OP_BNE=5, OP_J=2, OP_JAL=3);
  - FUNCT_JR=8 and FUNCT_SYSCALL=12.
- One natural sub-module, mips_npc_sel: purely combinational computation of pc4, btgt, jtgt, rtgt and next-PC priority. The top holds the registers, the FSM and the counters.

Test Plan:
- Reset then 3 idle edges (no controls) -> o_pc 0,4,8,12; o_imem_addr=3; o_cycle_cnt=3; other counters 0.
- pc=0x10, BEQ=1, alu_equal=1, imm16=16'hFFFC -> next o_pc=0x04; o_branch_cnt+1. Same with alu_equal=0 -> o_pc=0x14, count unchanged.
- pc=0x3000_0008, JUMP=1, jaddr26=26'h0000040 -> o_pc=0x3000_0100; JR=1, JUMP=1, rs_data=0x0000_0207 -> o_pc=0x0000_0204; o_jump_cnt+2.
- pc=0x20, halt_req=1, BNE=1, alu_equal=0 -> o_halted=1, o_pc stays 0x20 for 5 cycles, counters frozen. i_go 0->1 -> o_pc=0x24, o_halted=0.
- i_go held 1 entering HALT -> no resume until i_go drops and rises again. Assert i_rst during HALT -> o_pc=RESET_PC, o_halted=0, counters 0.
- Force the counters to 2^CNT_W-1 (CNT_W=4 build), then 1 RUN cycle -> o_cycle_cnt=0. pc=0xFFFF_FFFC idle -> o_pc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath.
package mips_pkg;

    // PC unit run/halt machine
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Primary opcodes handled by the decoder
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    // R-type function codes
    localparam logic [5:0] FUNCT_JR      = 6'd8;
    localparam logic [5:0] FUNCT_SYSCALL = 6'd12;

endpackage

// File: rtl/mips_npc_sel.sv
// Combinational next-PC selection: PC+4, branch, jump and register targets.
module mips_npc_sel (
    input  logic [31:0] pc_i,
    input  logic        beq_i,
    input  logic        bne_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        alu_equal_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jaddr26_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] pc4_o,
    output logic [31:0] next_pc_o,
    output logic        taken_o
);

    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [31:0] rtgt;

    // Target computation and priority JR > JUMP > taken branch > sequential
    always_comb begin
        pc4_o   = pc_i + 32'd4;
        btgt    = pc4_o + {{14{imm16_i[15]}}, imm16_i, 2'b00};
        jtgt    = {pc4_o[31:28], jaddr26_i, 2'b00};
        // Register target is forced word aligned
        rtgt    = rs_data_i & 32'hFFFF_FFFC;
        taken_o = (beq_i & alu_equal_i) | (bne_i & ~alu_equal_i);

        if (jr_i) begin
            next_pc_o = rtgt;
        end else if (jump_i) begin
            next_pc_o = jtgt;
        end else if (taken_o) begin
            next_pc_o = btgt;
        end else begin
            next_pc_o = pc4_o;
        end
    end

endmodule

// File: rtl/mips_1stage_pc_unit.sv
// Program counter, RUN/HALT machine and statistics counters of the single-cycle MIPS.
module mips_1stage_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_BEQ,
    input  logic               i_BNE,
    input  logic               i_JUMP,
    input  logic               i_JR,
    input  logic               i_halt_req,
    input  logic               i_alu_equal,
    input  logic [15:0]        i_imm16,
    input  logic [25:0]        i_jaddr26,
    input  logic [31:0]        i_rs_data,
    input  logic               i_go,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_pc_plus4,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_cycle_cnt,
    output logic [CNT_W-1:0]   o_jump_cnt,
    output logic [CNT_W-1:0]   o_branch_cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               go_q;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   jump_q, jump_d;
    logic [CNT_W-1:0]   branch_q, branch_d;

    logic [31:0]        pc4;
    logic [31:0]        next_pc;
    logic               taken;

    mips_npc_sel u_npc_sel (
        .pc_i        (pc_q),
        .beq_i       (i_BEQ),
        .bne_i       (i_BNE),
        .jump_i      (i_JUMP),
        .jr_i        (i_JR),
        .alu_equal_i (i_alu_equal),
        .imm16_i     (i_imm16),
        .jaddr26_i   (i_jaddr26),
        .rs_data_i   (i_rs_data),
        .pc4_o       (pc4),
        .next_pc_o   (next_pc),
        .taken_o     (taken)
    );

    // Next-state for the FSM, PC and counters
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cycle_d  = cycle_q;
        jump_d   = jump_q;
        branch_d = branch_q;

        unique case (state_q)
            ST_RUN: begin
                cycle_d = cycle_q + CntOne;
                if (i_halt_req) begin
                    // PC parks on the syscall; branch/jump stats are not charged
                    state_d = ST_HALT;
                end else begin
                    pc_d     = next_pc;
                    jump_d   = jump_q + (i_JUMP ? CntOne : '0);
                    branch_d = branch_q + (taken ? CntOne : '0);
                end
            end
            ST_HALT: begin
                // Only a fresh rising edge of go resumes, skipping the syscall
                if (i_go && !go_q) begin
                    state_d = ST_RUN;
                    pc_d    = pc4;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            go_q     <= 1'b0;
            cycle_q  <= '0;
            jump_q   <= '0;
            branch_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            go_q     <= i_go;
            cycle_q  <= cycle_d;
            jump_q   <= jump_d;
            branch_q <= branch_d;
        end
    end

    // Output mapping
    always_comb begin
        o_pc         = pc_q;
        o_pc_plus4   = pc4;
        o_imem_addr  = pc_q[IMEM_AW+1:2];
        o_halted     = (state_q == ST_HALT);
        o_cycle_cnt  = cycle_q;
        o_jump_cnt   = jump_q;
        o_branch_cnt = branch_q;
    end

endmodule

// File: tb/tb_mips_1stage_pc_unit.sv
// Directed self-checking bench for mips_1stage_pc_unit.
module tb_mips_1stage_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        beq, bne, jump, jr, halt_req, alu_equal, go;
    logic [15:0] imm16;
    logic [25:0] jaddr26;
    logic [31:0] rs_data;

    logic [31:0] pc, pc_plus4;
    logic [9:0]  imem_addr;
    logic        halted;
    logic [31:0] cycle_cnt, jump_cnt, branch_cnt;

    logic [31:0] s_pc, s_pc_plus4;
    logic [9:0]  s_imem_addr;
    logic        s_halted;
    logic [3:0]  s_cycle_cnt, s_jump_cnt, s_branch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_1stage_pc_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_BEQ        (beq),
        .i_BNE        (bne),
        .i_JUMP       (jump),
        .i_JR         (jr),
        .i_halt_req   (halt_req),
        .i_alu_equal  (alu_equal),
        .i_imm16      (imm16),
        .i_jaddr26    (jaddr26),
        .i_rs_data    (rs_data),
        .i_go         (go),
        .o_pc         (pc),
        .o_pc_plus4   (pc_plus4),
        .o_imem_addr  (imem_addr),
        .o_halted     (halted),
        .o_cycle_cnt  (cycle_cnt),
        .o_jump_cnt   (jump_cnt),
        .o_branch_cnt (branch_cnt)
    );

    // Narrow-counter build for wrap-around checks
    mips_1stage_pc_unit #(.CNT_W(4)) dut_small (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_BEQ        (beq),
        .i_BNE        (bne),
        .i_JUMP       (jump),
        .i_JR         (jr),
        .i_halt_req   (halt_req),
        .i_alu_equal  (alu_equal),
        .i_imm16      (imm16),
        .i_jaddr26    (jaddr26),
        .i_rs_data    (rs_data),
        .i_go         (go),
        .o_pc         (s_pc),
        .o_pc_plus4   (s_pc_plus4),
        .o_imem_addr  (s_imem_addr),
        .o_halted     (s_halted),
        .o_cycle_cnt  (s_cycle_cnt),
        .o_jump_cnt   (s_jump_cnt),
        .o_branch_cnt (s_branch_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beq = 0; bne = 0; jump = 0; jr = 0; halt_req = 0; alu_equal = 0;
        imm16 = '0; jaddr26 = '0; rs_data = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] c, input logic [31:0] j,
                             input logic [31:0] b);
        check({tag, "_cycle"}, cycle_cnt, c);
        check({tag, "_jump"}, jump_cnt, j);
        check({tag, "_branch"}, branch_cnt, b);
    endtask

    initial begin
        idle();
        go  = 0;
        rst = 1;
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check_cnt("rst", 0, 0, 0);
        rst = 0;

        // Sequential fetch
        step(); check("seq_pc1", pc, 32'h4);
        step(); check("seq_pc2", pc, 32'h8);
        step(); check("seq_pc3", pc, 32'hC);
        check("seq_imem", {22'b0, imem_addr}, 32'd3);
        check("seq_pc4", pc_plus4, 32'h10);
        check_cnt("seq", 3, 0, 0);
        step(); check("seq_pc_10", pc, 32'h10);

        // BEQ taken, backward offset
        beq = 1; alu_equal = 1; imm16 = 16'hFFFC;
        step(); idle();
        check("beq_taken_pc", pc, 32'h4);
        check_cnt("beq_taken", 5, 0, 1);

        step(); step(); step();
        check("back_to_10", pc, 32'h10);
        beq = 1; alu_equal = 0; imm16 = 16'hFFFC;
        step(); idle();
        check("beq_nt_pc", pc, 32'h14);
        check_cnt("beq_nt", 9, 0, 1);

        // JR to set up upper bits, then J and JR with low bits set
        jr = 1; jump = 1; rs_data = 32'h3000_0008;
        step(); idle();
        check("jr_pc", pc, 32'h3000_0008);
        jump = 1; jaddr26 = 26'h0000040;
        step(); idle();
        check("j_pc", pc, 32'h3000_0100);
        jr = 1; jump = 1; rs_data = 32'h0000_0207;
        step(); idle();
        check("jr_align_pc", pc, 32'h0000_0204);
        check_cnt("jumps", 12, 3, 1);

        // Halt together with a taken BNE: halt wins
        jr = 1; jump = 1; rs_data = 32'h20;
        step(); idle();
        check("pre_halt_pc", pc, 32'h20);
        halt_req = 1; bne = 1; alu_equal = 0; imm16 = 16'h0010;
        step(); idle();
        check("halt_flag", {31'b0, halted}, 32'h1);
        check("halt_pc", pc, 32'h20);
        check_cnt("halt", 14, 4, 1);
        for (int i = 0; i < 5; i++) begin
            jump = 1; beq = 1; alu_equal = 1;
            step();
            check("halt_hold_pc", pc, 32'h20);
        end
        idle();
        check_cnt("halt_frozen", 14, 4, 1);
        go = 1;
        step();
        check("resume_pc", pc, 32'h24);
        check("resume_flag", {31'b0, halted}, 32'h0);
        check_cnt("resume", 14, 4, 1);
        step();
        check("post_resume_pc", pc, 32'h28);

        // go held high across halt must not resume
        halt_req = 1;
        step(); idle();
        check("held_halt_flag", {31'b0, halted}, 32'h1);
        step(); step(); step();
        check("held_no_resume", {31'b0, halted}, 32'h1);
        check("held_pc", pc, 32'h28);
        go = 0;
        step();
        check("go_low_halted", {31'b0, halted}, 32'h1);
        go = 1;
        step();
        check("go_reedge_flag", {31'b0, halted}, 32'h0);
        check("go_reedge_pc", pc, 32'h2C);
        check_cnt("go_reedge", 16, 4, 1);

        // Reset during HALT, alongside a halt request
        halt_req = 1;
        step();
        check("halt2_flag", {31'b0, halted}, 32'h1);
        go = 0; rst = 1;
        step(); idle();
        check("rst_halt_pc", pc, 32'h0);
        check("rst_halt_flag", {31'b0, halted}, 32'h0);
        check_cnt("rst_halt", 0, 0, 0);
        rst = 0;

        // Narrow counter wrap
        for (int i = 0; i < 15; i++) step();
        check("small_cyc15", {28'b0, s_cycle_cnt}, 32'd15);
        step();
        check("small_cyc_wrap", {28'b0, s_cycle_cnt}, 32'd0);
        check("wide_cyc16", cycle_cnt, 32'd16);
        check("wrap_seq_pc", pc, 32'h40);

        // PC wrap at top of address space
        jr = 1; jump = 1; rs_data = 32'hFFFF_FFFC;
        step(); idle();
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_imem", {22'b0, imem_addr}, 32'h3FF);
        check("top_pc4", pc_plus4, 32'h0);
        step();
        check("wrap_pc", pc, 32'h0);

        // BNE taken, forward offset
        bne = 1; alu_equal = 0; imm16 = 16'h0002;
        step(); idle();
        check("bne_taken_pc", pc, 32'hC);
        check_cnt("bne_taken", 19, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
